// File: rtl/gray2rgb_stream.sv
// Purpose: stream expander turning 8-bit gray pixels into 24-bit RGB, with a per-pixel colour map and raster eol/eof flags.
// Latency: two register stages; a pixel presented in cycle c is on the outputs in cycle c+2 while rgb_ready stays high.
// Backpressure: both stages advance only when the output slot is empty or draining; gray_ready mirrors that advance enable.
module gray2rgb_stream #(
    parameter int WIDTH  = 640,
    parameter int HEIGHT = 480
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  mode,
    input  logic        gray_valid,
    output logic        gray_ready,
    input  logic [7:0]  gray_pixel,
    output logic        rgb_valid,
    input  logic        rgb_ready,
    output logic [23:0] rgb_pixel,
    output logic        rgb_eol,
    output logic        rgb_eof
);

    // Counter widths; a minimum of one bit keeps the declarations legal at the smallest sizes.
    localparam int CW = (WIDTH  > 1) ? $clog2(WIDTH)  : 1;
    localparam int RW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;

    localparam logic [CW-1:0] COL_LAST = CW'(WIDTH - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(HEIGHT - 1);

    // Colour map encodings carried alongside each pixel.
    localparam logic [1:0] MODE_REPL   = 2'd0;
    localparam logic [1:0] MODE_INV    = 2'd1;
    localparam logic [1:0] MODE_HEAT   = 2'd2;
    localparam logic [1:0] MODE_THRESH = 2'd3;

    // Pipeline control.
    logic en;
    logic accept;

    // Raster position of the next pixel to be accepted.
    logic [CW-1:0] col_q, col_d;
    logic [RW-1:0] row_q, row_d;
    logic          col_last;
    logic          row_last;

    // Stage 1: raw pixel, its mapping select and its position flags.
    logic       s1_vld_q,  s1_vld_d;
    logic [7:0] s1_gray_q, s1_gray_d;
    logic [1:0] s1_mode_q, s1_mode_d;
    logic       s1_eol_q,  s1_eol_d;
    logic       s1_eof_q,  s1_eof_d;

    // Stage 2: mapped colour and flags driving the outputs.
    logic        rgb_vld_q, rgb_vld_d;
    logic [23:0] rgb_pix_q, rgb_pix_d;
    logic        rgb_eol_q, rgb_eol_d;
    logic        rgb_eof_q, rgb_eof_d;

    // Mapping datapath.
    logic [7:0]  map_g;
    logic [7:0]  map_d;
    logic [7:0]  map_r_ch;
    logic [7:0]  map_g_ch;
    logic [7:0]  map_b_ch;
    logic [23:0] map_pix;

    // Advance when the output slot is empty or is being taken this cycle; ready is forced low during reset.
    always_comb begin
        en         = !rgb_vld_q || rgb_ready;
        gray_ready = en && !rst;
        accept     = gray_valid && gray_ready;
    end

    // Position flags are taken from the counters as they stand at the moment of accept.
    always_comb begin
        col_last = (col_q == COL_LAST);
        row_last = (row_q == ROW_LAST);
    end

    // Column/row counters move only on an accepted pixel and wrap at the frame edges.
    always_comb begin
        col_d = col_q;
        row_d = row_q;
        if (accept) begin
            if (col_last) begin
                col_d = '0;
                if (row_last) begin
                    row_d = '0;
                end else begin
                    row_d = row_q + RW'(1);
                end
            end else begin
                col_d = col_q + CW'(1);
            end
        end
    end

    // Stage 1 next state: valid follows the input on advance, payload is captured only on accept.
    always_comb begin
        s1_vld_d  = s1_vld_q;
        s1_gray_d = s1_gray_q;
        s1_mode_d = s1_mode_q;
        s1_eol_d  = s1_eol_q;
        s1_eof_d  = s1_eof_q;
        if (en) begin
            s1_vld_d = accept;
        end
        if (accept) begin
            s1_gray_d = gray_pixel;
            s1_mode_d = mode;
            s1_eol_d  = col_last;
            s1_eof_d  = col_last && row_last;
        end
    end

    // Colour map applied to the stage 1 pixel using the mode it was accepted with.
    always_comb begin
        map_g    = s1_gray_q;
        map_d    = {map_g[6:0], 1'b0};
        map_r_ch = map_g;
        map_g_ch = map_g;
        map_b_ch = map_g;
        case (s1_mode_q)
            MODE_REPL: begin
                map_r_ch = map_g;
                map_g_ch = map_g;
                map_b_ch = map_g;
            end
            MODE_INV: begin
                map_r_ch = 8'hFF - map_g;
                map_g_ch = 8'hFF - map_g;
                map_b_ch = 8'hFF - map_g;
            end
            MODE_HEAT: begin
                // Lower half ramps blue to red, upper half ramps red to yellow.
                if (!map_g[7]) begin
                    map_r_ch = map_d;
                    map_g_ch = 8'h00;
                    map_b_ch = 8'hFF - map_d;
                end else begin
                    map_r_ch = 8'hFF;
                    map_g_ch = map_d;
                    map_b_ch = 8'h00;
                end
            end
            MODE_THRESH: begin
                map_r_ch = {8{map_g[7]}};
                map_g_ch = {8{map_g[7]}};
                map_b_ch = {8{map_g[7]}};
            end
        endcase
        map_pix = {map_r_ch, map_g_ch, map_b_ch};
    end

    // Stage 2 next state: valid follows stage 1 on advance; payload updates only when a real pixel moves in.
    always_comb begin
        rgb_vld_d = rgb_vld_q;
        rgb_pix_d = rgb_pix_q;
        rgb_eol_d = rgb_eol_q;
        rgb_eof_d = rgb_eof_q;
        if (en) begin
            rgb_vld_d = s1_vld_q;
            if (s1_vld_q) begin
                rgb_pix_d = map_pix;
                rgb_eol_d = s1_eol_q;
                rgb_eof_d = s1_eof_q;
            end
        end
    end

    // State registers; reset discards in-flight pixels and restarts the raster at column 0, row 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col_q     <= '0;
            row_q     <= '0;
            s1_vld_q  <= 1'b0;
            s1_gray_q <= 8'h00;
            s1_mode_q <= MODE_REPL;
            s1_eol_q  <= 1'b0;
            s1_eof_q  <= 1'b0;
            rgb_vld_q <= 1'b0;
            rgb_pix_q <= 24'h000000;
            rgb_eol_q <= 1'b0;
            rgb_eof_q <= 1'b0;
        end else begin
            col_q     <= col_d;
            row_q     <= row_d;
            s1_vld_q  <= s1_vld_d;
            s1_gray_q <= s1_gray_d;
            s1_mode_q <= s1_mode_d;
            s1_eol_q  <= s1_eol_d;
            s1_eof_q  <= s1_eof_d;
            rgb_vld_q <= rgb_vld_d;
            rgb_pix_q <= rgb_pix_d;
            rgb_eol_q <= rgb_eol_d;
            rgb_eof_q <= rgb_eof_d;
        end
    end

    // Output drive straight from stage 2.
    always_comb begin
        rgb_valid = rgb_vld_q;
        rgb_pixel = rgb_pix_q;
        rgb_eol   = rgb_eol_q;
        rgb_eof   = rgb_eof_q;
    end

endmodule

// File: tb/tb_gray2rgb_stream.sv
// Bench for gray2rgb_stream on a small 4x2 raster: directed literal cases plus a randomized stream.
// Outputs are sampled on the falling edge; inputs change 1 time unit after the rising edge.
module tb_gray2rgb_stream;

    localparam int W = 4;
    localparam int H = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  mode = 2'd0;
    logic        gray_valid = 1'b0;
    logic        gray_ready;
    logic [7:0]  gray_pixel = 8'h00;
    logic        rgb_valid;
    logic        rgb_ready = 1'b1;
    logic [23:0] rgb_pixel;
    logic        rgb_eol;
    logic        rgb_eof;

    always #5 clk = ~clk;

    gray2rgb_stream #(.WIDTH(W), .HEIGHT(H)) dut (
        .clk       (clk),
        .rst       (rst),
        .mode      (mode),
        .gray_valid(gray_valid),
        .gray_ready(gray_ready),
        .gray_pixel(gray_pixel),
        .rgb_valid (rgb_valid),
        .rgb_ready (rgb_ready),
        .rgb_pixel (rgb_pixel),
        .rgb_eol   (rgb_eol),
        .rgb_eof   (rgb_eof)
    );

    typedef struct packed {
        logic [23:0] pix;
        logic        eol;
        logic        eof;
        logic [31:0] cyc;
    } ent_t;

    ent_t exp_q[$];
    ent_t obs_q[$];
    ent_t me;
    ent_t mo;
    int   tests = 0;
    int   fails = 0;
    int   cyc = 0;
    int   mcol = 0;
    int   mrow = 0;
    int   stall_lo = 0;
    logic st_prev = 1'b0;
    logic [25:0] st_val = '0;
    logic stim_done = 1'b0;

    // Reference colour map written directly from the mapping rules with integer arithmetic.
    function automatic logic [23:0] ref_map(input logic [1:0] m, input logic [7:0] gv);
        int g;
        int r;
        int gg;
        int b;
        g = int'(gv);
        case (m)
            2'd0: begin r = g; gg = g; b = g; end
            2'd1: begin r = 255 - g; gg = 255 - g; b = 255 - g; end
            2'd2: begin
                if (g < 128) begin r = 2 * g; gg = 0; b = 255 - 2 * g; end
                else begin r = 255; gg = 2 * (g - 128); b = 0; end
            end
            default: begin r = (g >= 128) ? 255 : 0; gg = r; b = r; end
        endcase
        return {r[7:0], gg[7:0], b[7:0]};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    function automatic ent_t obs_at(input int i);
        ent_t z;
        z = '1;
        if (i < obs_q.size()) z = obs_q[i];
        return z;
    endfunction

    // Scoreboard: model raster counters and expected pixels, compare every output transfer.
    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            chk("rst_valid", 32'(rgb_valid), 32'd0);
            chk("rst_pixel", 32'(rgb_pixel), 32'd0);
            chk("rst_flags", 32'({rgb_eol, rgb_eof}), 32'd0);
            chk("rst_gray_ready", 32'(gray_ready), 32'd0);
            exp_q.delete();
            mcol = 0;
            mrow = 0;
            st_prev = 1'b0;
        end else begin
            chk("ready_is_en", 32'(gray_ready), 32'(!rgb_valid || rgb_ready));
            if (st_prev) begin
                chk("stall_valid", 32'(rgb_valid), 32'd1);
                chk("stall_hold", 32'({rgb_pixel, rgb_eol, rgb_eof}), 32'(st_val));
            end
            if (rgb_valid && !rgb_ready) begin
                st_prev = 1'b1;
                st_val = {rgb_pixel, rgb_eol, rgb_eof};
                if (!gray_ready) stall_lo++;
            end else begin
                st_prev = 1'b0;
            end
            if (rgb_valid && rgb_ready) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_output: got %06h, expected no pending pixel", rgb_pixel);
                end else begin
                    me = exp_q.pop_front();
                    chk("pixel", 32'(rgb_pixel), 32'(me.pix));
                    chk("flags", 32'({rgb_eol, rgb_eof}), 32'({me.eol, me.eof}));
                    mo.pix = rgb_pixel;
                    mo.eol = rgb_eol;
                    mo.eof = rgb_eof;
                    mo.cyc = 32'(cyc) - me.cyc;
                    obs_q.push_back(mo);
                end
            end
            if (gray_valid && gray_ready) begin
                me.pix = ref_map(mode, gray_pixel);
                me.eol = (mcol == W - 1);
                me.eof = me.eol && (mrow == H - 1);
                me.cyc = 32'(cyc);
                exp_q.push_back(me);
                mcol++;
                if (mcol == W) begin
                    mcol = 0;
                    mrow = (mrow + 1) % H;
                end
            end
        end
    end

    task automatic send(input logic [1:0] m, input logic [7:0] p);
        int   n;
        logic took;
        n = 0;
        took = 1'b0;
        gray_valid = 1'b1;
        mode = m;
        gray_pixel = p;
        while (!took && n < 200) begin
            @(negedge clk);
            took = gray_ready;
            @(posedge clk);
            #1;
            n++;
        end
        if (!took) begin
            tests++;
            fails++;
            $display("FAIL send_timeout: got no accept in %0d cycles, expected accept", n);
        end
    endtask

    task automatic idle();
        gray_valid = 1'b0;
        gray_pixel = 8'($urandom);
        mode = 2'($urandom);
    endtask

    task automatic wait_obs(input int n);
        int k;
        k = 0;
        while (obs_q.size() < n && k < 500) begin
            @(posedge clk);
            #1;
            k++;
        end
        if (obs_q.size() < n) begin
            tests++;
            fails++;
            $display("FAIL wait_outputs: got %0d outputs, expected %0d", obs_q.size(), n);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    logic [7:0] bp_vals [6];
    ent_t       x;

    initial begin
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Replicate mode, back-to-back, fixed latency.
        obs_q.delete();
        send(2'd0, 8'h00);
        send(2'd0, 8'h7F);
        send(2'd0, 8'hFF);
        idle();
        wait_obs(3);
        x = obs_at(0); chk("m0_00", 32'(x.pix), 32'h000000); chk("m0_lat0", x.cyc, 32'd2);
        x = obs_at(1); chk("m0_7f", 32'(x.pix), 32'h7F7F7F); chk("m0_lat1", x.cyc, 32'd2);
        x = obs_at(2); chk("m0_ff", 32'(x.pix), 32'hFFFFFF); chk("m0_lat2", x.cyc, 32'd2);

        // Heat map on both halves of the range.
        obs_q.delete();
        send(2'd2, 8'h00);
        send(2'd2, 8'h40);
        send(2'd2, 8'h80);
        send(2'd2, 8'hC0);
        idle();
        wait_obs(4);
        x = obs_at(0); chk("heat_00", 32'(x.pix), 32'h0000FF);
        x = obs_at(1); chk("heat_40", 32'(x.pix), 32'h80007F);
        x = obs_at(2); chk("heat_80", 32'(x.pix), 32'hFF0000);
        x = obs_at(3); chk("heat_c0", 32'(x.pix), 32'hFF8000);

        // Invert and threshold around the midpoint; mode changes per pixel.
        obs_q.delete();
        send(2'd1, 8'h80);
        send(2'd1, 8'h7F);
        send(2'd3, 8'h80);
        send(2'd3, 8'h7F);
        idle();
        wait_obs(4);
        x = obs_at(0); chk("inv_80", 32'(x.pix), 32'h7F7F7F);
        x = obs_at(1); chk("inv_7f", 32'(x.pix), 32'h808080);
        x = obs_at(2); chk("thr_80", 32'(x.pix), 32'hFFFFFF);
        x = obs_at(3); chk("thr_7f", 32'(x.pix), 32'h000000);

        // Backpressure: 3-cycle stall while pixel 2 sits on the output.
        do_reset();
        obs_q.delete();
        stall_lo = 0;
        for (int i = 0; i < 6; i++) bp_vals[i] = 8'($urandom);
        fork
            begin
                for (int i = 0; i < 6; i++) send(2'd0, bp_vals[i]);
                idle();
            end
            begin
                int k;
                k = 0;
                while (!(obs_q.size() >= 2 && rgb_valid) && k < 100) begin
                    @(posedge clk);
                    #1;
                    k++;
                end
                rgb_ready = 1'b0;
                repeat (3) begin
                    @(posedge clk);
                    #1;
                end
                rgb_ready = 1'b1;
            end
        join
        wait_obs(6);
        chk("bp_count", 32'(obs_q.size()), 32'd6);
        chk("bp_ready_low", 32'(stall_lo), 32'd3);
        for (int i = 0; i < 6; i++) begin
            x = obs_at(i);
            chk("bp_order", 32'(x.pix), 32'({bp_vals[i], bp_vals[i], bp_vals[i]}));
        end

        // Frame flags over a full 4x2 frame plus one wrapped pixel.
        do_reset();
        obs_q.delete();
        for (int i = 0; i < 9; i++) send(2'($urandom), 8'($urandom));
        idle();
        wait_obs(9);
        for (int i = 0; i < 9; i++) begin
            x = obs_at(i);
            chk("frame_eol", 32'(x.eol), 32'((i == 3) || (i == 7)));
            chk("frame_eof", 32'(x.eof), 32'(i == 7));
        end

        // Reset in the middle of a frame, with a pixel on the output.
        do_reset();
        obs_q.delete();
        for (int i = 0; i < 5; i++) send(2'd0, 8'($urandom_range(1, 255)));
        idle();
        chk("pre_rst_valid", 32'(rgb_valid), 32'd1);
        rst = 1'b1;
        #1;
        chk("mid_rst_valid", 32'(rgb_valid), 32'd0);
        chk("mid_rst_pixel", 32'(rgb_pixel), 32'd0);
        chk("mid_rst_flags", 32'({rgb_eol, rgb_eof}), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        obs_q.delete();
        for (int i = 0; i < 4; i++) send(2'($urandom), 8'($urandom));
        idle();
        wait_obs(4);
        for (int i = 0; i < 4; i++) begin
            x = obs_at(i);
            chk("post_rst_eol", 32'(x.eol), 32'(i == 3));
        end

        // Randomized stream with random gaps and random downstream stalls.
        fork
            begin
                for (int i = 0; i < 400; i++) begin
                    if ($urandom_range(3) == 0) begin
                        idle();
                        @(posedge clk);
                        #1;
                    end else begin
                        send(2'($urandom), 8'($urandom));
                    end
                end
                idle();
                stim_done = 1'b1;
            end
            begin
                int k;
                k = 0;
                while (!stim_done && k < 20000) begin
                    @(posedge clk);
                    #1;
                    rgb_ready = ($urandom_range(9) < 7);
                    k++;
                end
                rgb_ready = 1'b1;
            end
        join
        begin
            int k;
            k = 0;
            while (exp_q.size() != 0 && k < 100) begin
                @(posedge clk);
                #1;
                k++;
            end
        end
        chk("drain_empty", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #800000;
        $display("FAIL watchdog: got no completion by %0t, expected finish", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
